// File: rtl/fifo_uart_tx_if.sv
// FIFO-side handshake and serial output bundle for fifo_uart_tx.
// The master modport is the transmitter and the slave modport is its environment.
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  en;
  logic [DATA_WIDTH-1:0] fifo_q;
  logic                  fifo_empty;
  logic                  fifo_ack;
  logic                  txd;
  logic                  busy;

  modport master (
    input  en, fifo_q, fifo_empty,
    output fifo_ack, txd, busy
  );

  modport slave (
    output en, fifo_q, fifo_empty,
    input  fifo_ack, txd, busy
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a show-ahead FIFO.
// Frames run back-to-back while the FIFO holds data and en is set.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sclr,
  fifo_uart_tx_if.master bus
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_MAX = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] STOP_MAX = BW'(STOP_BITS - 1);
  localparam logic          ODD      = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t                state;
  logic [CW-1:0]         baud_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_bit;
  logic                  txd_q;
  logic                  ack_q;
  logic                  busy_q;

  logic baud_wrap;
  logic last_stop;
  logic do_launch;

  assign baud_wrap = (baud_cnt == BAUD_MAX);
  assign last_stop = (state == STOP) && baud_wrap
                  && (bit_cnt == STOP_MAX);
  assign do_launch = bus.en && !bus.fifo_empty
                  && ((state == IDLE) || last_stop);

  assign bus.txd      = txd_q;
  assign bus.fifo_ack = ack_q;
  assign bus.busy     = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      txd_q     <= 1'b1;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else if (sclr) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
      txd_q     <= 1'b1;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (state != IDLE)
        baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;
      if (do_launch) begin
        state     <= START;
        baud_cnt  <= '0;
        bit_cnt   <= '0;
        shift_reg <= bus.fifo_q;
        par_bit   <= (^bus.fifo_q) ^ ODD;
        txd_q     <= 1'b0;
        ack_q     <= 1'b1;
        busy_q    <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            txd_q  <= 1'b1;
            busy_q <= 1'b0;
          end
          START: if (baud_wrap) begin
            state     <= DATA;
            bit_cnt   <= '0;
            txd_q     <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end
          DATA: if (baud_wrap) begin
            if (bit_cnt == DATA_MAX) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                state <= PARITY;
                txd_q <= par_bit;
              end else begin
                state <= STOP;
                txd_q <= 1'b1;
              end
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              txd_q     <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end
          PARITY: if (baud_wrap) begin
            state   <= STOP;
            bit_cnt <= '0;
            txd_q   <= 1'b1;
          end
          STOP: if (baud_wrap) begin
            if (bit_cnt == STOP_MAX) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            txd_q  <= 1'b1;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two configurations driven in lockstep,
// each checked cycle by cycle against a frame-level reference model.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int DW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclr = 1'b0;
  logic en = 1'b0;

  logic [7:0] fq [2];
  logic       fe [2];
  logic       txd_o [2];
  logic       busy_o [2];
  logic       ack_o [2];

  always #5 clk = ~clk;

  fifo_uart_tx_if #(.DATA_WIDTH(DW)) b0 ();
  fifo_uart_tx_if #(.DATA_WIDTH(DW)) b1 ();

  assign b0.en = en;
  assign b1.en = en;
  assign b0.fifo_q = fq[0];
  assign b1.fifo_q = fq[1];
  assign b0.fifo_empty = fe[0];
  assign b1.fifo_empty = fe[1];
  assign txd_o[0] = b0.txd;
  assign txd_o[1] = b1.txd;
  assign busy_o[0] = b0.busy;
  assign busy_o[1] = b1.busy;
  assign ack_o[0] = b0.fifo_ack;
  assign ack_o[1] = b1.fifo_ack;

  fifo_uart_tx #(
    .DATA_WIDTH(DW), .CLKS_PER_BIT(CPB),
    .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)
  ) u0 (
    .clk(clk), .rst(rst), .sclr(sclr), .bus(b0)
  );

  fifo_uart_tx #(
    .DATA_WIDTH(DW), .CLKS_PER_BIT(CPB),
    .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(1)
  ) u1 (
    .clk(clk), .rst(rst), .sclr(sclr), .bus(b1)
  );

  // frame shape per instance: bits per frame and parity setup
  int nbits [2] = '{10, 12};
  int par_en [2] = '{0, 1};
  int par_odd [2] = '{0, 1};

  int         rem [2] = '{0, 0};
  logic [15:0] frm [2];
  logic       exp_ack [2] = '{1'b0, 1'b0};

  logic [7:0] fmem [2][256];
  int hd [2] = '{0, 0};
  int tl [2] = '{0, 0};

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // start bit, data LSB first, optional parity, then stop ones
  function automatic logic [15:0] frame(int d, logic [7:0] w);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < DW; i++) f[i+1] = w[i];
    if (par_en[d] != 0) f[DW+1] = (^w) ^ par_odd[d][0];
    return f;
  endfunction

  task automatic drive_fifo();
    for (int d = 0; d < 2; d++) begin
      fq[d] = fmem[d][hd[d] % 256];
      fe[d] = (hd[d] == tl[d]);
    end
  endtask

  task automatic push(int d, logic [7:0] w);
    fmem[d][tl[d] % 256] = w;
    tl[d]++;
  endtask

  task automatic push2(logic [7:0] w);
    push(0, w);
    push(1, w);
  endtask

  task automatic tick();
    logic l_en, l_sclr;
    logic l_e [2];
    logic [7:0] l_q [2];
    logic l_ack [2];
    int idx, flen;
    logic ex;
    drive_fifo();
    l_en = en;
    l_sclr = sclr;
    for (int d = 0; d < 2; d++) begin
      l_e[d] = fe[d];
      l_q[d] = fq[d];
      l_ack[d] = ack_o[d];
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      flen = nbits[d] * CPB;
      exp_ack[d] = 1'b0;
      if (rst || l_sclr) begin
        rem[d] = 0;
      end else if (rem[d] <= 1 && l_en && !l_e[d]) begin
        frm[d] = frame(d, l_q[d]);
        rem[d] = flen;
        exp_ack[d] = 1'b1;
      end else if (rem[d] > 0) begin
        rem[d]--;
      end
      if (l_ack[d] && hd[d] != tl[d]) hd[d]++;
    end
    #1 drive_fifo();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      flen = nbits[d] * CPB;
      if (rem[d] == 0) begin
        ex = 1'b1;
      end else begin
        idx = (flen - rem[d]) / CPB;
        ex = frm[d][idx];
      end
      check($sformatf("txd%0d", d), 32'(txd_o[d]), 32'(ex));
      check($sformatf("busy%0d", d), 32'(busy_o[d]),
            32'(rem[d] > 0));
      check($sformatf("ack%0d", d), 32'(ack_o[d]),
            32'(exp_ack[d]));
    end
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      fq[d] = '0;
      fe[d] = 1'b1;
    end
    rst = 1'b1;
    en = 1'b1;
    run(3);
    rst = 1'b0;
    run(100);

    push2(8'h55);
    run(60);

    push2(8'hA3);
    push2(8'h0F);
    run(110);

    push2(8'h07);
    run(60);

    push2(8'h11);
    push2(8'h22);
    run(15);
    en = 1'b0;
    run(100);
    for (int d = 0; d < 2; d++)
      check($sformatf("held%0d", d), 32'(tl[d] - hd[d]), 32'd1);
    en = 1'b1;
    run(60);

    push2(8'h3C);
    push2(8'h5A);
    run(12);
    sclr = 1'b1;
    run(1);
    sclr = 1'b0;
    run(60);

    push2(8'h4B);
    push2(8'h6E);
    run(14);
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      rem[d] = 0;
      check($sformatf("arst_txd%0d", d), 32'(txd_o[d]), 32'd1);
      check($sformatf("arst_busy%0d", d), 32'(busy_o[d]), 32'd0);
    end
    run(2);
    rst = 1'b0;
    run(60);

    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < 2; d++)
        if ($urandom_range(0, 3) == 0 && (tl[d] - hd[d]) < 6)
          push(d, 8'($urandom));
      en = ($urandom_range(0, 15) != 0);
      sclr = ($urandom_range(0, 499) == 0);
      tick();
    end
    en = 1'b1;
    sclr = 1'b0;
    run(600);
    for (int d = 0; d < 2; d++)
      check($sformatf("drain%0d", d), 32'(hd[d] == tl[d]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
